dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 127 ++++++++++++
 tb/tb_dmem_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle word memory responder for the memory-stage load/store port.
// One access at a time; Stall while in flight, Done pulse with read data after LATENCY cycles.
module dmem_responder #(
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        err
);

    typedef enum logic {IDLE, BUSY} state_t;

    // The accept cycle is the first of the LATENCY cycles, so BUSY lasts LATENCY-1 cycles
    // and the access fires on the edge where cnt reaches 0.
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 2);

    state_t                r_state, w_state_nxt;
    logic [3:0]            r_cnt, w_cnt_nxt;
    logic                  r_op_wr, w_op_wr_nxt;
    logic [DEPTH_LOG2-1:0] r_idx, w_idx_nxt;
    logic [15:0]           r_data, w_data_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_err, w_err_nxt;
    logic [15:0]           r_dout;

    logic                  w_legal, w_illegal, w_fire, w_mem_op_wr, w_we, w_re;
    logic [DEPTH_LOG2-1:0] w_mem_idx;
    logic [15:0]           w_mem_wdata;
    logic                  w_unused;

    logic [15:0] r_mem [0:(1<<DEPTH_LOG2)-1];

    // Upper address bits alias onto the same words.
    assign w_unused = &{1'b0, Addr[15:DEPTH_LOG2+1]};

    assign w_legal   = (Rd ^ Wr) & ~Addr[0];
    assign w_illegal = (Rd | Wr) & ~w_legal;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_op_wr_nxt = r_op_wr;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        w_err_nxt   = 1'b0;
        w_fire      = 1'b0;
        w_mem_op_wr = r_op_wr;
        w_mem_idx   = r_idx;
        w_mem_wdata = r_data;
        Stall       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_legal) begin
                    Stall       = 1'b1;
                    w_op_wr_nxt = Wr;
                    w_idx_nxt   = Addr[DEPTH_LOG2:1];
                    w_data_nxt  = DataIn;
                    if (LATENCY == 1) begin
                        // Single-cycle access straight from the request inputs.
                        w_fire      = 1'b1;
                        w_mem_op_wr = Wr;
                        w_mem_idx   = Addr[DEPTH_LOG2:1];
                        w_mem_wdata = DataIn;
                    end else begin
                        w_cnt_nxt   = CNT_INIT;
                        w_state_nxt = BUSY;
                    end
                end else if (w_illegal) begin
                    w_err_nxt = 1'b1;
                end
            end
            BUSY: begin
                Stall = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_fire      = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_done_nxt = w_fire;
        w_we       = w_fire & w_mem_op_wr & ~rst;
        w_re       = w_fire & ~w_mem_op_wr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_op_wr <= 1'b0;
            r_idx   <= '0;
            r_data  <= 16'h0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_dout  <= 16'h0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op_wr <= w_op_wr_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_dout  <= w_re ? r_mem[w_mem_idx] : 16'h0;
        end
    end

    // Storage is not reset; a reset edge suppresses any pending write via w_we.
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_mem_idx] <= w_mem_wdata;
    end

    assign DataOut = r_dout;
    assign Done    = r_done;
    assign err     = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver pushes expected completions from a word-array
// model, a negedge monitor pops and compares whenever Done or err is seen.
module tb_dmem_responder;
    localparam int LAT = 4;
    localparam int DL2 = 10;
    localparam int NW  = 1 << DL2;

    typedef struct {
        bit          is_err;
        int          cyc;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Addr, DataIn;
    logic        Rd, Wr;
    logic [15:0] DataOut;
    logic        Done, Stall, err;

    dmem_responder #(.LATENCY(LAT), .DEPTH_LOG2(DL2)) dut (
        .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
        .DataOut(DataOut), .Done(Done), .Stall(Stall), .err(err)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          npass = 0;
    int          nchk = 0;
    logic [15:0] mdl [NW];
    exp_t        sb[$];
    exp_t        e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        nchk++;
        if (act === expv) npass++;
        else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, expv, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        Rd = 1'b0;
        Wr = 1'b0;
        repeat (n) begin
            @(negedge clk);
            chk("idle_stall", {31'b0, Stall}, 32'd0);
            tick();
        end
    endtask

    // Issue one request in the current cycle; on acceptance walk the busy cycles, leaving the
    // caller in the Done cycle so the next request goes back-to-back.
    task automatic req(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d,
                       input bit scramble);
        bit legal;
        int idx;
        Rd = rd; Wr = wr; Addr = a; DataIn = d;
        legal = (rd != wr) && !a[0];
        @(negedge clk);
        chk(legal ? "accept_stall" : "reject_stall", {31'b0, Stall}, {31'b0, legal});
        if (!legal) begin
            if (rd || wr) sb.push_back('{1'b1, cyc + 1, 16'h0});
            tick();
            Rd = 1'b0; Wr = 1'b0;
            return;
        end
        idx = (int'(a) >> 1) % NW;
        if (wr) begin
            mdl[idx] = d;
            sb.push_back('{1'b0, cyc + LAT, 16'h0});
        end else begin
            sb.push_back('{1'b0, cyc + LAT, mdl[idx]});
        end
        tick();
        Rd = 1'b0; Wr = 1'b0;
        for (int i = 1; i < LAT; i++) begin
            if (scramble) begin
                Rd = 1'($urandom); Wr = 1'($urandom);
                Addr = 16'($urandom); DataIn = 16'($urandom);
            end
            @(negedge clk);
            chk("busy_stall", {31'b0, Stall}, 32'd1);
            tick();
        end
        Rd = 1'b0; Wr = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (sb.size() != 0 && cyc > sb[0].cyc) begin
                chk("missing_output", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (Done || err) begin
                if (sb.size() == 0) begin
                    nchk++;
                    $display("FAIL unexpected_output: Done=%b err=%b at cycle %0d, none pending",
                             Done, err, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("out_is_err", {31'b0, err}, {31'b0, e.is_err});
                    chk("out_cycle", cyc, e.cyc);
                    if (!e.is_err) chk("out_data", {16'h0, DataOut}, {16'h0, e.data});
                end
            end else begin
                chk("dataout_zero", {16'h0, DataOut}, 32'd0);
            end
        end
    end

    initial begin
        int guard;
        int r;
        rst = 1'b1; Rd = 1'b0; Wr = 1'b0; Addr = 16'h0; DataIn = 16'h0;
        tick(); tick();
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_done", {31'b0, Done}, 32'd0);
            chk("rst_stall", {31'b0, Stall}, 32'd0);
            chk("rst_err", {31'b0, err}, 32'd0);
            chk("rst_dout", {16'h0, DataOut}, 32'd0);
            tick();
        end

        // Give every word a known value.
        for (int i = 0; i < NW; i++) req(1'b0, 1'b1, 16'(i * 2), 16'($urandom), 1'b0);
        idle(2);

        // Write then back-to-back read.
        req(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
        req(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
        idle(1);

        // Illegal requests leave storage untouched.
        req(1'b1, 1'b0, 16'h0011, 16'h0000, 1'b0);
        idle(1);
        req(1'b1, 1'b1, 16'h0020, 16'hDEAD, 1'b0);
        idle(1);
        req(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);
        idle(1);

        // Alias wrap: 0x0802 maps to the same word as 0x0002.
        req(1'b0, 1'b1, 16'h0002, 16'h1234, 1'b0);
        req(1'b1, 1'b0, 16'h0802, 16'h0000, 1'b0);
        idle(1);

        // Reset during a write aborts it.
        req(1'b0, 1'b1, 16'h0040, 16'h5555, 1'b0);
        idle(1);
        Wr = 1'b1; Addr = 16'h0040; DataIn = 16'hAAAA;
        @(negedge clk);
        chk("abort_accept_stall", {31'b0, Stall}, 32'd1);
        tick();
        Wr = 1'b0; Addr = 16'h1357; DataIn = 16'h2468;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            chk("abort_no_done", {31'b0, Done}, 32'd0);
            chk("abort_stall", {31'b0, Stall}, 32'd0);
            tick();
        end
        req(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0);
        idle(1);

        // Inputs scrambled while busy.
        req(1'b0, 1'b1, 16'h0100, 16'hC0DE, 1'b1);
        req(1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1);

        // Randomized mix.
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: req(1'b1, 1'b1, 16'($urandom) & 16'hFFFE, 16'($urandom), 1'b0);
                1: req(1'($urandom), 1'b1, 16'($urandom) | 16'h0001, 16'($urandom), 1'b0);
                2: idle($urandom_range(1, 3));
                default: req(r[0], !r[0], 16'($urandom) & 16'hFFFE, 16'($urandom),
                             1'($urandom));
            endcase
        end

        Rd = 1'b0; Wr = 1'b0;
        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            tick();
            guard++;
        end
        chk("drain_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
